// File: rtl/h14tx_rst_seq_if.sv
// Signal bundle between the HDMI 1.4 TX reset sequencer and its environment.
// The master side is the sequencer. It receives lock/sw_rst and drives the
// per-channel resets and status.
interface h14tx_rst_seq_if #(
  parameter int NUM_CH = 3
);
  logic              lock;
  logic              sw_rst;
  logic [NUM_CH-1:0] sync_rst_n;
  logic              done;
  logic [7:0]        lock_loss_cnt;

  modport master (
    input  lock,
    input  sw_rst,
    output sync_rst_n,
    output done,
    output lock_loss_cnt
  );

  modport slave (
    output lock,
    output sw_rst,
    input  sync_rst_n,
    input  done,
    input  lock_loss_cnt
  );
endinterface

// File: rtl/h14tx_rst_seq.sv
// Reset sequencer for the HDMI 1.4 transmitter clock domain.
// The sequencer first synchronises the PLL lock and requires it to stay high
// for LOCK_FILTER cycles. It then holds every reset for MIN_ASSERT cycles and
// releases the NUM_CH active-low resets one after another, STAGGER cycles apart.
// Lock loss or sw_rst from any post-filter state restarts the whole sequence.
// NUM_CH must match the NUM_CH of the connected interface instance.
//
// state     | meaning
// WAIT_LOCK | all resets asserted, filtering synchronised lock
// HOLD      | lock qualified, enforcing minimum reset assertion
// RELEASE   | channels being released one per STAGGER interval
// RUN       | all channels released, watching for abort
module h14tx_rst_seq #(
  parameter int NUM_CH      = 3,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILTER = 16,
  parameter int MIN_ASSERT  = 8,
  parameter int STAGGER     = 4
) (
  input logic              clk,
  input logic              rst,
  h14tx_rst_seq_if.master  rs
);

  localparam int FW = $clog2(LOCK_FILTER + 1);
  localparam int HW = $clog2(MIN_ASSERT + 1);
  localparam int SW = $clog2(STAGGER + 1);
  localparam int CW = $clog2(NUM_CH + 1);

  localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILTER - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MIN_ASSERT - 1);
  localparam logic [SW-1:0] STG_LAST  = SW'(STAGGER - 1);
  localparam logic [CW-1:0] CH_LAST   = CW'(NUM_CH - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [FW-1:0]     filt_q, filt_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [SW-1:0]     stg_q, stg_d;
  logic [CW-1:0]     ch_q, ch_d;
  logic [NUM_CH-1:0] rst_n_q, rst_n_d;
  logic              done_q, done_d;
  logic [7:0]        loss_q, loss_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic                   abort;

  // lock crosses into clk only through this chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], rs.lock};
  end

  assign lock_s = sync_q[SYNC_STAGES-1];
  assign abort  = !lock_s || rs.sw_rst;

  // state, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_LOCK;
      filt_q  <= '0;
      hold_q  <= '0;
      stg_q   <= '0;
      ch_q    <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      filt_q  <= filt_d;
      hold_q  <= hold_d;
      stg_q   <= stg_d;
      ch_q    <= ch_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
      loss_q  <= loss_d;
    end
  end

  // next-state and output decode; any abort after WAIT_LOCK restarts from scratch
  always_comb begin
    state_d = state_q;
    filt_d  = filt_q;
    hold_d  = hold_q;
    stg_d   = stg_q;
    ch_d    = ch_q;
    rst_n_d = rst_n_q;
    done_d  = done_q;
    loss_d  = loss_q;

    if (state_q != WAIT_LOCK && abort) begin
      // only a lock drop seen in RUN counts as a lock loss
      if (state_q == RUN && !lock_s && loss_q != 8'hFF)
        loss_d = loss_q + 8'd1;
      state_d = WAIT_LOCK;
      filt_d  = '0;
      hold_d  = '0;
      stg_d   = '0;
      ch_d    = '0;
      rst_n_d = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          rst_n_d = '0;
          done_d  = 1'b0;
          if (rs.sw_rst || !lock_s) begin
            filt_d = '0;
          end else if (filt_q == FILT_LAST) begin
            filt_d  = '0;
            hold_d  = '0;
            state_d = HOLD;
          end else begin
            filt_d = filt_q + FW'(1);
          end
        end
        HOLD: begin
          if (hold_q == HOLD_LAST) begin
            hold_d  = '0;
            rst_n_d = rst_n_q | NUM_CH'(1);
            stg_d   = '0;
            if (NUM_CH == 1) begin
              done_d  = 1'b1;
              state_d = RUN;
            end else begin
              ch_d    = CW'(1);
              state_d = RELEASE;
            end
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        RELEASE: begin
          if (stg_q == STG_LAST) begin
            stg_d   = '0;
            rst_n_d = rst_n_q | (NUM_CH'(1) << ch_q);
            if (ch_q == CH_LAST) begin
              done_d  = 1'b1;
              state_d = RUN;
            end else begin
              ch_d = ch_q + CW'(1);
            end
          end else begin
            stg_d = stg_q + SW'(1);
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  assign rs.sync_rst_n    = rst_n_q;
  assign rs.done          = done_q;
  assign rs.lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_h14tx_rst_seq.sv
// Directed bench for h14tx_rst_seq: the default configuration plus two
// parameter variants.
module tb_h14tx_rst_seq;

  logic clk;
  logic rst;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  h14tx_rst_seq_if #(.NUM_CH(3)) ifa ();
  h14tx_rst_seq_if #(.NUM_CH(1)) ifb ();
  h14tx_rst_seq_if #(.NUM_CH(4)) ifc ();

  h14tx_rst_seq #(.NUM_CH(3)) dut_a (
    .clk (clk),
    .rst (rst),
    .rs  (ifa)
  );

  h14tx_rst_seq #(.NUM_CH(1), .STAGGER(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .rs  (ifb)
  );

  h14tx_rst_seq #(.NUM_CH(4), .SYNC_STAGES(3)) dut_c (
    .clk (clk),
    .rst (rst),
    .rs  (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // channel k is expected released once e >= t0 + k*stg
  function automatic logic [3:0] exp_mask(int e, int t0, int stg, int nch);
    logic [3:0] m;
    m = '0;
    for (int k = 0; k < nch; k++)
      if (e >= t0 + k * stg) m[k] = 1'b1;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifa.lock = 1'b1; ifa.sw_rst = 1'b0;
    ifb.lock = 1'b0; ifb.sw_rst = 1'b0;
    ifc.lock = 1'b0; ifc.sw_rst = 1'b0;
    tick(); tick(); tick();
    vec_cnt++;
    if (ifa.sync_rst_n !== 3'b000) begin
      err_cnt++; $display("FAIL reset_rst_n got %b exp 000", ifa.sync_rst_n);
    end
    vec_cnt++;
    if (ifa.done !== 1'b0) begin
      err_cnt++; $display("FAIL reset_done got %b exp 0", ifa.done);
    end
    vec_cnt++;
    if (ifa.lock_loss_cnt !== 8'd0) begin
      err_cnt++; $display("FAIL reset_cnt got %0d exp 0", ifa.lock_loss_cnt);
    end
  endtask

  task automatic test_power_up(string tag);
    logic [3:0] m;
    rst = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      tick();
      m = exp_mask(e, 26, 4, 3);
      vec_cnt++;
      if (ifa.sync_rst_n !== m[2:0]) begin
        err_cnt++; $display("FAIL %s_rst_n e=%0d got %b exp %b", tag, e, ifa.sync_rst_n, m[2:0]);
      end
      vec_cnt++;
      if (ifa.done !== (e >= 34)) begin
        err_cnt++; $display("FAIL %s_done e=%0d got %b exp %b", tag, e, ifa.done, (e >= 34));
      end
      vec_cnt++;
      if (ifa.lock_loss_cnt !== 8'd0) begin
        err_cnt++; $display("FAIL %s_cnt e=%0d got %0d exp 0", tag, e, ifa.lock_loss_cnt);
      end
    end
  endtask

  task automatic test_lock_toggle();
    bit ok;
    rst = 1'b1;
    ifa.lock = 1'b0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 120; i++) begin
      ifa.lock = ((i / 10) % 2) == 0;
      tick();
      vec_cnt++;
      if (ifa.sync_rst_n !== 3'b000 || ifa.done !== 1'b0) begin
        err_cnt++;
        $display("FAIL toggle i=%0d got rst_n=%b done=%b exp 000/0", i, ifa.sync_rst_n, ifa.done);
      end
    end
    ifa.lock = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin
      tick();
      if (ifa.done === 1'b1) ok = 1'b1;
    end
    vec_cnt++;
    if (!ok) begin
      err_cnt++; $display("FAIL toggle_relock got done=%b exp 1 within 80 cycles", ifa.done);
    end
  endtask

  task automatic test_lock_loss();
    logic [3:0] m;
    ifa.lock = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      tick();
      vec_cnt++;
      if (ifa.sync_rst_n !== ((e < 3) ? 3'b111 : 3'b000)) begin
        err_cnt++; $display("FAIL loss_rst_n e=%0d got %b", e, ifa.sync_rst_n);
      end
      vec_cnt++;
      if (ifa.done !== (e < 3)) begin
        err_cnt++; $display("FAIL loss_done e=%0d got %b exp %b", e, ifa.done, (e < 3));
      end
      vec_cnt++;
      if (ifa.lock_loss_cnt !== ((e < 3) ? 8'd0 : 8'd1)) begin
        err_cnt++; $display("FAIL loss_cnt e=%0d got %0d", e, ifa.lock_loss_cnt);
      end
    end
    ifa.lock = 1'b1;
    for (int e = 1; e <= 36; e++) begin
      tick();
      m = exp_mask(e, 26, 4, 3);
      vec_cnt++;
      if (ifa.sync_rst_n !== m[2:0] || ifa.done !== (e >= 34)) begin
        err_cnt++;
        $display("FAIL relock e=%0d got rst_n=%b done=%b exp %b/%b", e, ifa.sync_rst_n, ifa.done, m[2:0], (e >= 34));
      end
    end
  endtask

  task automatic test_sw_rst();
    logic [3:0] m;
    // first restart from RUN, then a second one mid-RELEASE
    for (int pass = 0; pass < 2; pass++) begin
      ifa.sw_rst = 1'b1;
      tick();
      ifa.sw_rst = 1'b0;
      vec_cnt++;
      if (ifa.sync_rst_n !== 3'b000 || ifa.done !== 1'b0) begin
        err_cnt++;
        $display("FAIL swrst_abort pass=%0d got rst_n=%b done=%b exp 000/0", pass, ifa.sync_rst_n, ifa.done);
      end
      for (int e = 2; e <= ((pass == 0) ? 26 : 34); e++) begin
        tick();
        m = exp_mask(e, 25, 4, 3);
        vec_cnt++;
        if (ifa.sync_rst_n !== m[2:0] || ifa.done !== (e >= 33)) begin
          err_cnt++;
          $display("FAIL swrst_seq pass=%0d e=%0d got rst_n=%b done=%b exp %b/%b", pass, e, ifa.sync_rst_n, ifa.done, m[2:0], (e >= 33));
        end
        vec_cnt++;
        if (ifa.lock_loss_cnt !== 8'd1) begin
          err_cnt++; $display("FAIL swrst_cnt e=%0d got %0d exp 1", e, ifa.lock_loss_cnt);
        end
      end
    end
  endtask

  task automatic test_async_rst();
    ifa.sw_rst = 1'b1;
    tick();
    ifa.sw_rst = 1'b0;
    for (int e = 2; e <= 30; e++) tick();
    vec_cnt++;
    if (ifa.sync_rst_n !== 3'b011) begin
      err_cnt++; $display("FAIL arst_pre got %b exp 011", ifa.sync_rst_n);
    end
    #2;
    rst = 1'b1;
    #1;
    vec_cnt++;
    if (ifa.sync_rst_n !== 3'b000 || ifa.done !== 1'b0) begin
      err_cnt++; $display("FAIL arst_out got rst_n=%b done=%b exp 000/0", ifa.sync_rst_n, ifa.done);
    end
    vec_cnt++;
    if (ifa.lock_loss_cnt !== 8'd0) begin
      err_cnt++; $display("FAIL arst_cnt got %0d exp 0", ifa.lock_loss_cnt);
    end
    tick(); tick();
    test_power_up("arst_pwr");
  endtask

  task automatic test_param_sweep();
    logic [3:0] m;
    rst = 1'b1;
    ifa.lock = 1'b1;
    ifb.lock = 1'b1;
    ifc.lock = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int e = 1; e <= 45; e++) begin
      tick();
      m = exp_mask(e, 26, 1, 1);
      vec_cnt++;
      if (ifb.sync_rst_n !== m[0] || ifb.done !== (e >= 26)) begin
        err_cnt++;
        $display("FAIL sweep_b e=%0d got rst_n=%b done=%b exp %b/%b", e, ifb.sync_rst_n, ifb.done, m[0], (e >= 26));
      end
      m = exp_mask(e, 27, 4, 4);
      vec_cnt++;
      if (ifc.sync_rst_n !== m || ifc.done !== (e >= 39)) begin
        err_cnt++;
        $display("FAIL sweep_c e=%0d got rst_n=%b done=%b exp %b/%b", e, ifc.sync_rst_n, ifc.done, m, (e >= 39));
      end
    end
  endtask

  task automatic test_saturation();
    bit ok;
    int exp_cnt;
    for (int i = 0; i < 300; i++) begin
      ifa.lock = 1'b0;
      tick(); tick(); tick(); tick();
      ifa.lock = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 60 && !ok; c++) begin
        tick();
        if (ifa.done === 1'b1) ok = 1'b1;
      end
      vec_cnt++;
      if (!ok) begin
        err_cnt++; $display("FAIL sat_relock i=%0d got done=%b exp 1 within 60 cycles", i, ifa.done);
      end
      exp_cnt = (i + 1 > 255) ? 255 : i + 1;
      vec_cnt++;
      if (ifa.lock_loss_cnt !== 8'(exp_cnt)) begin
        err_cnt++; $display("FAIL sat_cnt i=%0d got %0d exp %0d", i, ifa.lock_loss_cnt, exp_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_power_up("pwr");
    test_lock_toggle();
    test_lock_loss();
    test_sw_rst();
    test_async_rst();
    test_param_sweep();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
